mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port image memory between NUM_REQ requesters (Controller, filter, output writer).
//  Arbitrates round-robin, issues one access at a time, and returns read data to the granted requester.
//  Sits between the requesters and the memory; drives the memory's MEMRW/MEMADDR interface.
// PARAMETERS
//  NUM_REQ      3   number of requesters, 2..4
//  DATA_WIDTH   24  pixel/data word width
//  BUS_WIDTH    32  memory address width
//  MEM_LATENCY  1   cycles from read command to valid Arb_MEMRDATA, 1..4
// PORTS
//  Arb_CLK      in   1                  clock, rising edge
//  Arb_RST      in   1                  reset, asynchronous, active-low
//  Arb_REQ      in   NUM_REQ            per-requester request, held until grant seen
//  Arb_RW       in   2*NUM_REQ          per-requester op: 01 read, 10 write (00/11 illegal)
//  Arb_ADDR     in   BUS_WIDTH*NUM_REQ  per-requester address, slice i = requester i
//  Arb_WDATA    in   DATA_WIDTH*NUM_REQ per-requester write data
//  Arb_GNT      out  NUM_REQ            one-hot, 1-cycle grant pulse
//  Arb_RVALID   out  NUM_REQ            one-hot, 1-cycle read-data-valid pulse
//  Arb_RDATA    out  DATA_WIDTH         read data, shared by all requesters
//  Arb_BUSY     out  1                  high in ISSUE or RDWAIT
//  Arb_MEMRW    out  2                  memory op: 00 idle, 01 read, 10 write
//  Arb_MEMADDR  out  BUS_WIDTH          memory address
//  Arb_MEMWDATA out  DATA_WIDTH         memory write data
//  Arb_MEMRDATA in   DATA_WIDTH         memory read data
// BEHAVIOUR
//  - All outputs registered. Reset (Arb_RST=0) clears all outputs to 0, state to IDLE, rr_ptr to NUM_REQ-1.
//  - Eligible requester i: Arb_REQ[i]=1 and Arb_RW slice is 01 or 10. 00/11 is never granted, no error flagged.
//  - FSM IDLE: if any requester is eligible, pick the winner, then at the clock edge:
//    - GNT[winner]=1, MEMRW/MEMADDR/MEMWDATA = winner's slices, rr_ptr=winner;
//    - next state ISSUE.
//  - ISSUE (1 cycle, command cycle C):
//    - GNT, MEMRW, MEMADDR, MEMWDATA valid; no new arbitration this cycle.
//    - Next edge: GNT=0, MEMRW=00. Write -> IDLE; read -> RDWAIT.
//  - RDWAIT: counts MEM_LATENCY-1 further cycles.
//    - At end of cycle C+MEM_LATENCY: Arb_RDATA<=Arb_MEMRDATA, RVALID[winner]=1 for one cycle (C+MEM_LATENCY+1).
//    - Then IDLE.
//  - Arb_RDATA holds its value until the next read completes.
//  - Latency REQ->GNT: 1 cycle from the IDLE cycle in which REQ is sampled.
//  - Throughput: write every 2 cycles; read every MEM_LATENCY+2 cycles.
//  - Round-robin: search order rr_ptr+1, rr_ptr+2, ... mod NUM_REQ. After reset, requester 0 wins a tie.
//  - Requester drops or changes REQ before its grant: no grant; re-evaluated next IDLE cycle.
//  - Requester keeps REQ high after its GNT: treated as a new request in the next IDLE.
//  - Arb_MEMADDR/Arb_MEMWDATA keep their last value while MEMRW=00.
//  - Reset during RDWAIT: pending read discarded; no RVALID after reset release.
//  - MEM_LATENCY or NUM_REQ out of range: $error at elaboration.
// CONFIGURATION
//  ARB_FIXED_PRI_EN:
//    - Defined: requester 0 (Controller) always wins when eligible; requesters 1..NUM_REQ-1 round-robin among
//      themselves, with rr_ptr updated only by their grants.
//    - Undefined: pure round-robin over all requesters as above.
// TESTING
//  - Write: REQ[1]=1, RW=10, ADDR=0x40, WDATA=0xABCDEF ->
//    next cycle GNT=010, MEMRW=10, MEMADDR=0x40, MEMWDATA=0xABCDEF; cycle after: MEMRW=00.
//  - Read, MEM_LATENCY=2: REQ[2], ADDR=0x10, memory returns 0x123456 at C+2 ->
//    RVALID=100 and RDATA=0x123456 at C+3, BUSY low at C+4.
//  - All 3 requesters hold REQ with reads after reset -> grant order 0,1,2,0,1; one RVALID per grant, same index.
//  - Reset asserted during RDWAIT -> all outputs 0 immediately; no RVALID after release; next grant goes to requester 0.
//  - REQ[0]=1 with RW=11, REQ[1]=1 with RW=10 -> only requester 1 granted; requester 0 never granted.
//  - ARB_FIXED_PRI_EN defined, REQ[0..2] all held -> grant order 0,0,0...;
//    drop REQ[0] -> grants alternate 1,2.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one single-port image memory
//               between NUM_REQ requesters. One access at a time; read data
//               is returned on a shared bus with a one-hot valid pulse.
//               Optional macro ARB_FIXED_PRI_EN: requester 0 always wins when
//               eligible, requesters 1..NUM_REQ-1 round-robin among themselves.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int DATA_WIDTH  = 24,
    parameter int BUS_WIDTH   = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                            Arb_CLK,
    input  logic                            Arb_RST,
    input  logic [NUM_REQ-1:0]              Arb_REQ,
    input  logic [2*NUM_REQ-1:0]            Arb_RW,
    input  logic [BUS_WIDTH*NUM_REQ-1:0]    Arb_ADDR,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]   Arb_WDATA,
    output logic [NUM_REQ-1:0]              Arb_GNT,
    output logic [NUM_REQ-1:0]              Arb_RVALID,
    output logic [DATA_WIDTH-1:0]           Arb_RDATA,
    output logic                            Arb_BUSY,
    output logic [1:0]                      Arb_MEMRW,
    output logic [BUS_WIDTH-1:0]            Arb_MEMADDR,
    output logic [DATA_WIDTH-1:0]           Arb_MEMWDATA,
    input  logic [DATA_WIDTH-1:0]           Arb_MEMRDATA
);

    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 2;

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    // Parameter range checks at elaboration
    generate
        if ((NUM_REQ < 2) || (NUM_REQ > 4)) begin : g_bad_num_req
            $error("mem_arbiter: NUM_REQ must be in 2..4");
        end
        if ((MEM_LATENCY < 1) || (MEM_LATENCY > 4)) begin : g_bad_latency
            $error("mem_arbiter: MEM_LATENCY must be in 1..4");
        end
    endgenerate

    state_t                  r_state,    w_state;
    logic [PTR_W-1:0]        r_rr_ptr,   w_rr_ptr;
    logic [PTR_W-1:0]        r_owner,    w_owner;
    logic [CNT_W-1:0]        r_rd_cnt,   w_rd_cnt;
    logic [NUM_REQ-1:0]      r_gnt,      w_gnt;
    logic [NUM_REQ-1:0]      r_rvalid,   w_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata,    w_rdata;
    logic                    r_busy,     w_busy;
    logic [1:0]              r_memrw,    w_memrw;
    logic [BUS_WIDTH-1:0]    r_memaddr,  w_memaddr;
    logic [DATA_WIDTH-1:0]   r_memwdata, w_memwdata;

    logic [NUM_REQ-1:0]      w_elig;
    logic                    w_found;
    logic [PTR_W-1:0]        w_win;

    // Requester index reached 'off' steps after ptr, wrapping at NUM_REQ
    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] ptr, input int off);
        int v_sum;
        v_sum = (int'(ptr) + off) % NUM_REQ;
        return PTR_W'(v_sum);
    endfunction

    // A requester is eligible only with a legal read or write opcode
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = Arb_REQ[i] &
                        ((Arb_RW[2*i +: 2] == OP_READ) | (Arb_RW[2*i +: 2] == OP_WRITE));
        end
    end

    // Winner selection: scan from rr_ptr+1 upward; lowest offset is assigned last and wins
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
`ifdef ARB_FIXED_PRI_EN
            if (w_elig[rr_idx(r_rr_ptr, off)] && (rr_idx(r_rr_ptr, off) != '0)) begin
`else
            if (w_elig[rr_idx(r_rr_ptr, off)]) begin
`endif
                w_found = 1'b1;
                w_win   = rr_idx(r_rr_ptr, off);
            end
        end
`ifdef ARB_FIXED_PRI_EN
        // The Controller pre-empts the round-robin group whenever it is eligible
        if (w_elig[0]) begin
            w_found = 1'b1;
            w_win   = '0;
        end
`endif
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        w_state    = r_state;
        w_rr_ptr   = r_rr_ptr;
        w_owner    = r_owner;
        w_rd_cnt   = r_rd_cnt;
        w_gnt      = '0;
        w_rvalid   = '0;
        w_rdata    = r_rdata;
        w_memrw    = OP_IDLE;
        w_memaddr  = r_memaddr;
        w_memwdata = r_memwdata;
        w_busy     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (w_win == PTR_W'(i)) begin
                            w_gnt[i]   = 1'b1;
                            w_memrw    = Arb_RW[2*i +: 2];
                            w_memaddr  = Arb_ADDR[BUS_WIDTH*i +: BUS_WIDTH];
                            w_memwdata = Arb_WDATA[DATA_WIDTH*i +: DATA_WIDTH];
                        end
                    end
`ifdef ARB_FIXED_PRI_EN
                    // Controller grants do not disturb the rotation of the others
                    if (w_win != '0) begin
                        w_rr_ptr = w_win;
                    end
`else
                    w_rr_ptr = w_win;
`endif
                    w_owner = w_win;
                    w_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_rd_cnt = '0;
                w_state  = (r_memrw == OP_READ) ? ST_RDWAIT : ST_IDLE;
            end
            ST_RDWAIT: begin
                if (r_rd_cnt == CNT_W'(MEM_LATENCY - 1)) begin
                    w_rdata = Arb_MEMRDATA;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (r_owner == PTR_W'(i)) begin
                            w_rvalid[i] = 1'b1;
                        end
                    end
                    w_state = ST_IDLE;
                end else begin
                    w_rd_cnt = r_rd_cnt + 1'b1;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        w_busy = (w_state == ST_ISSUE) || (w_state == ST_RDWAIT);
    end

    // State and output registers; reset discards any read in flight
    always_ff @(posedge Arb_CLK or negedge Arb_RST) begin
        if (!Arb_RST) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= PTR_W'(NUM_REQ - 1);
            r_owner    <= '0;
            r_rd_cnt   <= '0;
            r_gnt      <= '0;
            r_rvalid   <= '0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
            r_memrw    <= OP_IDLE;
            r_memaddr  <= '0;
            r_memwdata <= '0;
        end else begin
            r_state    <= w_state;
            r_rr_ptr   <= w_rr_ptr;
            r_owner    <= w_owner;
            r_rd_cnt   <= w_rd_cnt;
            r_gnt      <= w_gnt;
            r_rvalid   <= w_rvalid;
            r_rdata    <= w_rdata;
            r_busy     <= w_busy;
            r_memrw    <= w_memrw;
            r_memaddr  <= w_memaddr;
            r_memwdata <= w_memwdata;
        end
    end

    assign Arb_GNT      = r_gnt;
    assign Arb_RVALID   = r_rvalid;
    assign Arb_RDATA    = r_rdata;
    assign Arb_BUSY     = r_busy;
    assign Arb_MEMRW    = r_memrw;
    assign Arb_MEMADDR  = r_memaddr;
    assign Arb_MEMWDATA = r_memwdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed scenarios then
//               randomized requesters against a transaction-level model with
//               a behavioural latency-LAT memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DW      = 24;
    localparam int BW      = 32;
    localparam int LAT     = 2;

    logic                   Arb_CLK = 1'b0;
    logic                   Arb_RST = 1'b1;
    logic [NUM_REQ-1:0]     Arb_REQ = '0;
    logic [2*NUM_REQ-1:0]   Arb_RW = '0;
    logic [BW*NUM_REQ-1:0]  Arb_ADDR = '0;
    logic [DW*NUM_REQ-1:0]  Arb_WDATA = '0;
    logic [NUM_REQ-1:0]     Arb_GNT;
    logic [NUM_REQ-1:0]     Arb_RVALID;
    logic [DW-1:0]          Arb_RDATA;
    logic                   Arb_BUSY;
    logic [1:0]             Arb_MEMRW;
    logic [BW-1:0]          Arb_MEMADDR;
    logic [DW-1:0]          Arb_MEMWDATA;
    logic [DW-1:0]          Arb_MEMRDATA = '0;

    mem_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_WIDTH  (DW),
        .BUS_WIDTH   (BW),
        .MEM_LATENCY (LAT)
    ) dut (
        .Arb_CLK      (Arb_CLK),
        .Arb_RST      (Arb_RST),
        .Arb_REQ      (Arb_REQ),
        .Arb_RW       (Arb_RW),
        .Arb_ADDR     (Arb_ADDR),
        .Arb_WDATA    (Arb_WDATA),
        .Arb_GNT      (Arb_GNT),
        .Arb_RVALID   (Arb_RVALID),
        .Arb_RDATA    (Arb_RDATA),
        .Arb_BUSY     (Arb_BUSY),
        .Arb_MEMRW    (Arb_MEMRW),
        .Arb_MEMADDR  (Arb_MEMADDR),
        .Arb_MEMWDATA (Arb_MEMWDATA),
        .Arb_MEMRDATA (Arb_MEMRDATA)
    );

    always #5 Arb_CLK = ~Arb_CLK;

    int tests = 0;
    int fails = 0;
    int n     = 0;      // cycle index, advanced just after each rising edge

    // Transaction-level reference: one scheduled access and its timeline
    int          g_cycle, g_idx, busy_end, rv_cycle, rv_idx, free_cycle, rr;
    logic [1:0]  g_rw;
    logic [BW-1:0] g_addr, m_addr;
    logic [DW-1:0] g_wdata, m_wdata, m_rdata, rv_data;
    bit          in_reset;
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] dut_mem [256];
    int          resp_cycle;
    logic [7:0]  resp_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic bit eligible(input int i);
        return Arb_REQ[i] && (Arb_RW[2*i +: 2] == 2'b01 || Arb_RW[2*i +: 2] == 2'b10);
    endfunction

    task automatic model_clear();
        g_cycle = -1; busy_end = -1; rv_cycle = -1; resp_cycle = -1;
        g_idx = 0; rv_idx = 0; g_rw = 2'b00;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        rr = NUM_REQ - 1;
    endtask

    // Decide, from the inputs held in cycle n, which access is granted in cycle n+1
    task automatic arb_eval();
        int win;
        win = -1;
        if (in_reset || n < free_cycle) return;
`ifdef ARB_FIXED_PRI_EN
        if (eligible(0)) win = 0;
        else for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (rr + k) % NUM_REQ;
            if (win < 0 && c != 0 && eligible(c)) win = c;
        end
        if (win > 0) rr = win;
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (rr + k) % NUM_REQ;
            if (win < 0 && eligible(c)) win = c;
        end
        if (win >= 0) rr = win;
`endif
        if (win < 0) return;
        g_cycle = n + 1;
        g_idx   = win;
        g_rw    = Arb_RW[2*win +: 2];
        g_addr  = Arb_ADDR[BW*win +: BW];
        g_wdata = Arb_WDATA[DW*win +: DW];
        if (g_rw == 2'b10) begin
            ref_mem[g_addr[7:0]] = g_wdata;
            busy_end   = g_cycle;
            free_cycle = g_cycle + 1;
        end else begin
            busy_end   = g_cycle + LAT;
            free_cycle = g_cycle + LAT + 1;
            rv_cycle   = g_cycle + LAT + 1;
            rv_idx     = win;
            rv_data    = ref_mem[g_addr[7:0]];
        end
    endtask

    // Compare every output against the model, then play the memory's part
    task automatic check_outputs();
        logic [NUM_REQ-1:0] eg, erv;
        eg  = (n == g_cycle) ? onehot(g_idx) : '0;
        erv = (n == rv_cycle) ? onehot(rv_idx) : '0;
        if (n == g_cycle) begin m_addr = g_addr; m_wdata = g_wdata; end
        if (n == rv_cycle) m_rdata = rv_data;
        chk("gnt",     Arb_GNT,      eg);
        chk("memrw",   Arb_MEMRW,    (n == g_cycle) ? g_rw : 2'b00);
        chk("memaddr", Arb_MEMADDR,  m_addr);
        chk("memwdat", Arb_MEMWDATA, m_wdata);
        chk("rvalid",  Arb_RVALID,   erv);
        chk("rdata",   Arb_RDATA,    m_rdata);
        chk("busy",    Arb_BUSY,     (n >= g_cycle && n <= busy_end) ? 1'b1 : 1'b0);
        if (Arb_MEMRW == 2'b10) begin
            dut_mem[Arb_MEMADDR[7:0]] = Arb_MEMWDATA;
        end else if (Arb_MEMRW == 2'b01) begin
            resp_cycle = n + LAT;
            resp_addr  = Arb_MEMADDR[7:0];
        end
        Arb_MEMRDATA = (n == resp_cycle) ? dut_mem[resp_addr] : DW'($urandom);
    endtask

    task automatic tick();
        arb_eval();
        @(posedge Arb_CLK);
        #1;
        n++;
        check_outputs();
    endtask

    task automatic do_reset();
        Arb_RST = 1'b0;
        Arb_REQ = '0;
        #1;
        model_clear();
        in_reset = 1'b1;
        check_outputs();
        tick();
        tick();
        Arb_RST    = 1'b1;
        in_reset   = 1'b0;
        free_cycle = n;
    endtask

    task automatic set_req(input int i, input logic [1:0] rw, input logic [BW-1:0] a, input logic [DW-1:0] d);
        Arb_REQ[i]          = 1'b1;
        Arb_RW[2*i +: 2]    = rw;
        Arb_ADDR[BW*i +: BW] = a;
        Arb_WDATA[DW*i +: DW] = d;
    endtask

    task automatic new_op(input int i);
        int r;
        logic [1:0] rw;
        r  = $urandom_range(9, 0);
        rw = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
        set_req(i, rw, BW'($urandom), DW'($urandom));
    endtask

    task automatic drive_random();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (Arb_GNT[i]) begin
                if ($urandom_range(1, 0) == 0) Arb_REQ[i] = 1'b0;
                else new_op(i);
            end else if (!Arb_REQ[i]) begin
                if ($urandom_range(3, 0) == 0) new_op(i);
            end else if ($urandom_range(15, 0) == 0) begin
                Arb_REQ[i] = 1'b0;
            end
        end
    endtask

    initial begin
        int seen;
        int order [5];
        int exp_order [5];
        int g0, g1;
        bit got;

        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = DW'($urandom);
            dut_mem[i] = ref_mem[i];
        end
        model_clear();
        free_cycle = 0;
        #2;
        do_reset();

        // Single write from requester 1
        set_req(1, 2'b10, 32'h40, 24'hABCDEF);
        tick();
        chk("wr_gnt",   Arb_GNT,      3'b010);
        chk("wr_memrw", Arb_MEMRW,    2'b10);
        chk("wr_addr",  Arb_MEMADDR,  32'h40);
        chk("wr_wdata", Arb_MEMWDATA, 24'hABCDEF);
        Arb_REQ = '0;
        tick();
        chk("wr_after", Arb_MEMRW,    2'b00);
        chk("wr_hold",  Arb_MEMADDR,  32'h40);

        // Single read from requester 2, memory returns 0x123456
        ref_mem[8'h10] = 24'h123456;
        dut_mem[8'h10] = 24'h123456;
        set_req(2, 2'b01, 32'h10, 24'h0);
        tick();
        chk("rd_gnt", Arb_GNT, 3'b100);
        Arb_REQ = '0;
        tick(); tick(); tick();
        chk("rd_rvalid", Arb_RVALID, 3'b100);
        chk("rd_rdata",  Arb_RDATA,  24'h123456);
        tick();
        chk("rd_busy_low", Arb_BUSY, 1'b0);

        // All requesters hold reads: grant order 0,1,2,0,1
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'b01, BW'($urandom), DW'(0));
        exp_order = '{0, 1, 2, 0, 1};
        for (int k = 0; k < 5; k++) order[k] = -1;
        seen = 0;
        for (int c = 0; c < 60 && seen < 5; c++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++) if (Arb_GNT[i] && seen < 5) begin order[seen] = i; seen++; end
        end
        chk("rr_count", seen, 5);
        for (int k = 0; k < 5; k++) chk("rr_order", order[k], exp_order[k]);

        // Reset while a read is waiting for memory data
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin tick(); got = (Arb_GNT != '0); end
        chk("pre_rst_grant", got, 1'b1);
        tick();
        chk("pre_rst_busy", Arb_BUSY, 1'b1);
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'b01, BW'($urandom), DW'(0));
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin tick(); got = (Arb_GNT != '0); end
        chk("post_rst_gnt", Arb_GNT, 3'b001);

        // Illegal opcode on requester 0 is never granted
        do_reset();
        set_req(0, 2'b11, 32'h5, 24'h1);
        set_req(1, 2'b10, 32'h6, 24'h2);
        g0 = 0; g1 = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (Arb_GNT[0]) g0++;
            if (Arb_GNT[1]) g1++;
        end
        chk("ill_g0", g0, 0);
        chk("ill_g1", g1, 6);

`ifdef ARB_FIXED_PRI_EN
        // Controller wins every time while eligible; others then alternate
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 2'b10, BW'($urandom), DW'($urandom));
        g0 = 0;
        for (int c = 0; c < 6; c++) begin tick(); if (Arb_GNT[0]) g0++; end
        chk("fix_g0", g0, 3);
        Arb_REQ[0] = 1'b0;
        exp_order = '{1, 2, 1, 2, 1};
        for (int k = 0; k < 5; k++) order[k] = -1;
        seen = 0;
        for (int c = 0; c < 40 && seen < 5; c++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++) if (Arb_GNT[i] && seen < 5) begin order[seen] = i; seen++; end
        end
        for (int k = 0; k < 5; k++) chk("fix_order", order[k], exp_order[k]);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            drive_random();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
